mem_bus_arbiter: RTL and testbench

Two-requester arbiter in front of the single data-bus port of memory_controller (write_enable/addr/data_in/data_out). Shares the port between the CPU load/store path (requester 0) and a secondary master such as a DMA or debug loader (requester 1). Each requester uses a valid/ready handshake. Transactions are sequenced through a fixed 3-state FSM with round-robin fairness.

---
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the memory_controller data port (IDLE -> ISSUE -> WAIT).
// Optional feature macro MEM_ARB_LOCK_EN adds req0_lock/req1_lock so one owner can hold the bus across a read-modify-write.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [2:0]        req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2:0]        req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
`ifdef MEM_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        ready_q, ready_d;

  logic [1:0] valid;
  logic       rr_id;
  logic       locked_grant;
  logic       grant_id;

  assign valid = {req1_valid, req0_valid};
  // On a tie the requester that did not win last time goes first.
  assign rr_id = (&valid) ? ~last_grant_q : valid[1];

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  // A held lock only sticks while its owner keeps asking; otherwise round-robin resumes.
  assign locked_grant = lock_q & valid[owner_q];
`else
  assign locked_grant = 1'b0;
`endif

  assign grant_id = locked_grant ? owner_q : rr_id;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_in_d     = mem_in_q;
    rdata_d      = rdata_q;
    ready_d      = 2'b00;
`ifdef MEM_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        lock_d = 1'b0;
`endif
        if (|valid) begin
          state_d     = ISSUE;
          owner_d     = grant_id;
          if (!locked_grant) last_grant_d = grant_id;
          mem_write_d = grant_id ? req1_we    : req0_we;
          mem_addr_d  = grant_id ? req1_addr  : req0_addr;
          mem_in_d    = grant_id ? req1_wdata : req0_wdata;
        end
      end
      ISSUE: begin
        mem_write_d = 3'b000;
        state_d     = WAIT;
      end
      WAIT: begin
        rdata_d = mem_out;
        ready_d = owner_q ? 2'b10 : 2'b01;
        state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
        lock_d  = owner_q ? req1_lock : req0_lock;
`endif
      end
      default: begin
        mem_write_d = 3'b000;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_write_q  <= '0;
      mem_addr_q   <= '0;
      mem_in_q     <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_in_q     <= mem_in_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign rdata      = rdata_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_in     = mem_in_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-timeline model (grant edge g -> write strobe at g, ready at g+2, next grant from g+3).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]  req0_we = '0, req1_we = '0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        req0_ready, req1_ready, busy;
  logic [31:0] rdata, mem_addr, mem_in;
  logic [31:0] mem_out = '0;
  logic [2:0]  mem_write;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
`ifdef MEM_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rdata(rdata), .mem_write(mem_write), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0F0F) + 32'h1234;
  endfunction

  // Memory stand-in: registered read, one cycle after the address.
  always @(posedge clk) mem_out <= rd_model(mem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: cyc counts edges, g is the edge of the latest grant.
  int          cyc = 0;
  int          g = -100;
  bit          m_own, m_last = 1'b1, m_lock;
  logic [2:0]  m_we = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, e_rdata = '0;
  bit          e_rdy0, e_rdy1;
  int          ord[$];
  int          ord_t[$];

  task automatic model_edge();
    bit w, gr;
    cyc++;
    if (rst) begin
      g = -100; m_last = 1'b1; m_lock = 1'b0; m_we = '0;
      m_addr = '0; m_wdata = '0; e_rdata = '0; e_rdy0 = 1'b0; e_rdy1 = 1'b0;
      return;
    end
    e_rdy0 = 1'b0; e_rdy1 = 1'b0;
    if (cyc == g + 2) begin
      if (m_own) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
      e_rdata = rd_model(m_addr);
      m_lock  = m_own ? req1_lock : req0_lock;
    end
    if (cyc >= g + 3) begin
      gr = 1'b0; w = 1'b0;
      if (m_lock && (m_own ? req1_valid : req0_valid)) begin
        w = m_own; gr = 1'b1;
      end else if (req0_valid || req1_valid) begin
        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_last = w; gr = 1'b1;
      end
      m_lock = 1'b0;
      if (gr) begin
        g = cyc; m_own = w;
        m_we    = w ? req1_we    : req0_we;
        m_addr  = w ? req1_addr  : req0_addr;
        m_wdata = w ? req1_wdata : req0_wdata;
      end
    end
  endtask

  task automatic compare();
    check("mem_write",  32'(mem_write), 32'((cyc == g) ? m_we : 3'b000));
    check("mem_addr",   mem_addr, m_addr);
    check("mem_in",     mem_in, m_wdata);
    check("busy",       32'(busy), 32'(cyc == g || cyc == g + 1));
    check("req0_ready", 32'(req0_ready), 32'(e_rdy0));
    check("req1_ready", 32'(req1_ready), 32'(e_rdy1));
    if (e_rdy0 || e_rdy1) check("rdata", rdata, e_rdata);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
    if (req0_ready === 1'b1) begin ord.push_back(0); ord_t.push_back(cyc); end
    if (req1_ready === 1'b1) begin ord.push_back(1); ord_t.push_back(cyc); end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] we,
                         input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    req0_lock = 1'b0; req1_lock = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ord.delete(); ord_t.delete();
  endtask

  task automatic check_order(input string tag, input int e0, input int e1, input int e2);
    check({tag, "_count"}, 32'(ord.size() >= 3), 32'd1);
    if (ord.size() >= 3) begin
      check({tag, "_0"}, 32'(ord[0]), 32'(e0));
      check({tag, "_1"}, 32'(ord[1]), 32'(e1));
      check({tag, "_2"}, 32'(ord[2]), 32'(e2));
    end
  endtask

  int pulses;
  int done;

  initial begin
    // Reset state
    do_reset();
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_in", mem_in, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);

    // Single read by requester 0
    set_req(0, 1'b1, 3'b000, 32'h10, 32'h0);
    tick();
    check("rd_we", 32'(mem_write), 32'd0);
    check("rd_addr", mem_addr, 32'h10);
    set_req(0, 1'b0, 3'b000, 32'h10, 32'h0);
    tick();
    tick();
    check("rd_ready0", 32'(req0_ready), 32'd1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_ready1", 32'(req1_ready), 32'd0);

    // Single byte write by requester 1
    ord.delete();
    set_req(1, 1'b1, 3'b100, 32'h20, 32'hAB);
    tick();
    check("bw_we", 32'(mem_write), 32'd4);
    check("bw_addr", mem_addr, 32'h20);
    check("bw_data", mem_in, 32'hAB);
    set_req(1, 1'b0, 3'b100, 32'h20, 32'hAB);
    tick();
    check("bw_we_off", 32'(mem_write), 32'd0);
    tick();
    tick();
    check("bw_one_ready", 32'(ord.size()), 32'd1);

    // Contention: both always valid
    do_reset();
    set_req(0, 1'b1, 3'b000, 32'h100, 32'h0);
    set_req(1, 1'b1, 3'b000, 32'h200, 32'h0);
    repeat (12) tick();
    check("ct_count", 32'(ord.size()), 32'd4);
    if (ord.size() == 4) begin
      for (int i = 0; i < 4; i++) check("ct_order", 32'(ord[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("ct_spacing", 32'(ord_t[i] - ord_t[i-1]), 32'd3);
    end

    // Back-to-back word writes from requester 0
    do_reset();
    set_req(0, 1'b1, 3'b001, 32'h300, 32'h11);
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    pulses = 0; done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_write === 3'b001) pulses++;
      if (req0_ready === 1'b1) begin
        done++;
        if (done < 3) set_req(0, 1'b1, 3'b001, req0_addr + 32'h4, req0_wdata + 32'h1);
        else          set_req(0, 1'b0, 3'b001, req0_addr, req0_wdata);
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_readies", 32'(ord.size()), 32'd3);

    // Reset during ISSUE of a word write
    do_reset();
    set_req(0, 1'b1, 3'b001, 32'h400, 32'h55);
    tick();
    check("rm_issue_we", 32'(mem_write), 32'd1);
    set_req(0, 1'b0, 3'b001, 32'h400, 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_we", 32'(mem_write), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(req0_ready), 32'd0);
    set_req(0, 1'b1, 3'b000, 32'h500, 32'h0);
    set_req(1, 1'b1, 3'b000, 32'h600, 32'h0);
    tick();
    set_req(0, 1'b0, 3'b000, 32'h500, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h600, 32'h0);
    tick();
    check("rm_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    check("rm_tie_req0", 32'(req0_ready), 32'd1);
    check("rm_tie_req1", 32'(req1_ready), 32'd0);

`ifdef MEM_ARB_LOCK_EN
    // Lock held by requester 0 for two transactions
    do_reset();
    set_req(0, 1'b1, 3'b000, 32'h40, 32'h0);
    set_req(1, 1'b1, 3'b000, 32'h50, 32'h0);
    req0_lock = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) req0_lock = 1'b0;
    end
    check_order("lock_on", 0, 0, 1);
    do_reset();
    set_req(0, 1'b1, 3'b000, 32'h40, 32'h0);
    set_req(1, 1'b1, 3'b000, 32'h50, 32'h0);
    repeat (10) tick();
    check_order("lock_off", 0, 1, 0);
`endif

    // Random traffic, including illegal write codes and occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom, $urandom);
      set_req(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
`ifdef MEM_ARB_LOCK_EN
      req0_lock = 1'($urandom_range(0, 1));
      req1_lock = 1'($urandom_range(0, 1));
`endif
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
